// File: rtl/lc3b_mem_arbiter.sv
// Merges the CPU instruction and data memory ports onto one physical memory port.
// Data has priority; a bounded streak counter guarantees instruction fetch progress.
module lc3b_mem_arbiter #(
   parameter int unsigned WIDTH        = 16,
   parameter int unsigned MAX_D_STREAK = 4
) (
   input  logic             clk,
   input  logic             rst_n,

   input  logic             i_mem_read,
   input  logic [WIDTH-1:0] i_mem_address,
   output logic             i_mem_resp,
   output logic [WIDTH-1:0] i_mem_rdata,

   input  logic             d_mem_read,
   input  logic             d_mem_write,
   input  logic [1:0]       d_mem_byte_enable,
   input  logic [WIDTH-1:0] d_mem_address,
   input  logic [WIDTH-1:0] d_mem_wdata,
   output logic             d_mem_resp,
   output logic [WIDTH-1:0] d_mem_rdata,

   output logic             pmem_read,
   output logic             pmem_write,
   output logic [1:0]       pmem_byte_enable,
   output logic [WIDTH-1:0] pmem_address,
   output logic [WIDTH-1:0] pmem_wdata,
   input  logic             pmem_resp,
   input  logic [WIDTH-1:0] pmem_rdata
);

   localparam int unsigned  SW    = 4;
   localparam logic [SW-1:0] MAX_S = SW'(MAX_D_STREAK);

   typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;

   state_t        state;
   logic [SW-1:0] streak;

   logic d_req_c;
   logic grant_d_c;

   // Data wins unless the instruction side has already waited through a full streak.
   assign d_req_c   = d_mem_read | d_mem_write;
   assign grant_d_c = d_req_c && !(i_mem_read && (streak == MAX_S));

   assign i_mem_resp  = (state == I_BUSY) && pmem_resp;
   assign d_mem_resp  = (state == D_BUSY) && pmem_resp;
   assign i_mem_rdata = pmem_rdata;
   assign d_mem_rdata = pmem_rdata;

   // Arbitration FSM with registered physical-port outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= IDLE;
         streak           <= '0;
         pmem_read        <= 1'b0;
         pmem_write       <= 1'b0;
         pmem_byte_enable <= 2'b00;
         pmem_address     <= '0;
         pmem_wdata       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_d_c) begin
                  pmem_address <= d_mem_address;
                  pmem_wdata   <= d_mem_wdata;
                  if (d_mem_write) begin
                     pmem_write       <= 1'b1;
                     pmem_byte_enable <= d_mem_byte_enable;
                  end else begin
                     pmem_read        <= 1'b1;
                     pmem_byte_enable <= 2'b11;
                  end
                  if (i_mem_read)
                     streak <= (streak < MAX_S) ? streak + SW'(1) : MAX_S;
                  else
                     streak <= '0;
                  state <= D_BUSY;
               end else if (i_mem_read) begin
                  pmem_address     <= i_mem_address;
                  pmem_read        <= 1'b1;
                  pmem_byte_enable <= 2'b11;
                  pmem_wdata       <= '0;
                  streak           <= '0;
                  state            <= I_BUSY;
               end
            end
            I_BUSY, D_BUSY: begin
               if (pmem_resp) begin
                  pmem_read        <= 1'b0;
                  pmem_write       <= 1'b0;
                  pmem_byte_enable <= 2'b00;
                  state            <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lc3b_mem_arbiter.sv
// Self-checking bench for lc3b_mem_arbiter: directed vector table, hand-written
// streak/reset sequences, and randomized traffic against a transaction-level model.
module tb_lc3b_mem_arbiter;

   localparam int unsigned W    = 16;
   localparam int          MAXS = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          i_mem_read;
   logic [W-1:0]  i_mem_address;
   logic          i_mem_resp;
   logic [W-1:0]  i_mem_rdata;
   logic          d_mem_read;
   logic          d_mem_write;
   logic [1:0]    d_mem_byte_enable;
   logic [W-1:0]  d_mem_address;
   logic [W-1:0]  d_mem_wdata;
   logic          d_mem_resp;
   logic [W-1:0]  d_mem_rdata;
   logic          pmem_read;
   logic          pmem_write;
   logic [1:0]    pmem_byte_enable;
   logic [W-1:0]  pmem_address;
   logic [W-1:0]  pmem_wdata;
   logic          pmem_resp;
   logic [W-1:0]  pmem_rdata;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   lc3b_mem_arbiter #(.WIDTH(W), .MAX_D_STREAK(MAXS)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_mem_read(i_mem_read), .i_mem_address(i_mem_address),
      .i_mem_resp(i_mem_resp), .i_mem_rdata(i_mem_rdata),
      .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
      .d_mem_byte_enable(d_mem_byte_enable), .d_mem_address(d_mem_address),
      .d_mem_wdata(d_mem_wdata), .d_mem_resp(d_mem_resp), .d_mem_rdata(d_mem_rdata),
      .pmem_read(pmem_read), .pmem_write(pmem_write),
      .pmem_byte_enable(pmem_byte_enable), .pmem_address(pmem_address),
      .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
   );

   typedef struct {
      bit         i_rd;
      logic [15:0] i_addr;
      bit         d_rd;
      bit         d_wr;
      logic [1:0] be;
      logic [15:0] d_addr;
      logic [15:0] d_wd;
      bit         presp;
      logic [15:0] prdata;
      bit         e_rd;
      bit         e_wr;
      logic [1:0] e_be;
      logic [15:0] e_addr;
      logic [15:0] e_wd;
      bit         e_iresp;
      bit         e_dresp;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      i_mem_read = 0; i_mem_address = '0;
      d_mem_read = 0; d_mem_write = 0; d_mem_byte_enable = 2'b00;
      d_mem_address = '0; d_mem_wdata = '0;
      pmem_resp = 0; pmem_rdata = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 0;
      idle_inputs();
      @(negedge clk);
      rst_n = 1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_strobes"}, {29'd0, pmem_read, pmem_write, 1'b0}, 32'd0);
      chk({tag, "_be"}, {30'd0, pmem_byte_enable}, 32'd0);
      chk({tag, "_addr"}, {16'd0, pmem_address}, 32'd0);
      chk({tag, "_wdata"}, {16'd0, pmem_wdata}, 32'd0);
      chk({tag, "_resp"}, {30'd0, i_mem_resp, d_mem_resp}, 32'd0);
   endtask

   // Physical memory answers each strobe in its first cycle; records grant order.
   task automatic collect(input int n, input bit ack_last, output string seq);
      int got = 0;
      int cyc = 0;
      seq = "";
      while (got < n && cyc < 200) begin
         @(negedge clk);
         cyc++;
         pmem_resp = 0;
         #1;
         if (pmem_read | pmem_write) begin
            got++;
            seq = {seq, (pmem_address == 16'h0100) ? "I" : "D"};
            pmem_resp = (got < n) || ack_last;
         end
      end
      if (got < n) begin
         checks++; errors++;
         $display("FAIL collect_timeout actual=%0d grants expected=%0d", got, n);
      end
   endtask

   // Transaction-level reference model state.
   bit         m_busy;
   bit         m_is_d;
   bit         m_rd, m_wr;
   logic [1:0] m_be;
   logic [15:0] m_addr, m_wd;
   int         m_d_run;

   initial begin
      string seq;
      rst_n = 0;
      idle_inputs();
      #1;
      chk_all_zero("reset");
      @(negedge clk);
      rst_n = 1;

      //        i  iaddr     d  w  be     daddr     dwd       pr prdata    rd wr be    addr      wd        ir dr
      vecs[0]  = '{1, 16'h1234, 0, 0, 2'b00, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 2'b00, 16'h0000, 16'h0000, 0, 0};
      vecs[1]  = '{1, 16'h1234, 0, 0, 2'b00, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0, 2'b11, 16'h1234, 16'h0000, 0, 0};
      vecs[2]  = '{1, 16'h9999, 0, 0, 2'b00, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0, 2'b11, 16'h1234, 16'h0000, 0, 0};
      vecs[3]  = '{1, 16'h9999, 0, 0, 2'b00, 16'h0000, 16'h0000, 1, 16'hABCD, 1, 0, 2'b11, 16'h1234, 16'h0000, 1, 0};
      vecs[4]  = '{0, 16'h0000, 0, 0, 2'b00, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 2'b00, 16'h1234, 16'h0000, 0, 0};
      vecs[5]  = '{0, 16'h0000, 0, 1, 2'b01, 16'h0040, 16'h00FF, 0, 16'h0000, 0, 0, 2'b00, 16'h1234, 16'h0000, 0, 0};
      vecs[6]  = '{0, 16'h0000, 0, 1, 2'b10, 16'h0BAD, 16'hDEAD, 0, 16'h0000, 0, 1, 2'b01, 16'h0040, 16'h00FF, 0, 0};
      vecs[7]  = '{0, 16'h0000, 0, 1, 2'b10, 16'h0BAD, 16'hDEAD, 1, 16'h0000, 0, 1, 2'b01, 16'h0040, 16'h00FF, 0, 1};
      vecs[8]  = '{0, 16'h0000, 0, 0, 2'b00, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 2'b00, 16'h0040, 16'h00FF, 0, 0};
      vecs[9]  = '{1, 16'h2000, 1, 0, 2'b00, 16'h3000, 16'h5555, 0, 16'h0000, 0, 0, 2'b00, 16'h0040, 16'h00FF, 0, 0};
      vecs[10] = '{1, 16'h2000, 1, 0, 2'b00, 16'h3000, 16'h5555, 1, 16'h1111, 1, 0, 2'b11, 16'h3000, 16'h5555, 0, 1};
      vecs[11] = '{1, 16'h2000, 0, 0, 2'b00, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 2'b00, 16'h3000, 16'h5555, 0, 0};
      vecs[12] = '{1, 16'h2000, 0, 0, 2'b00, 16'h0000, 16'h0000, 1, 16'h2222, 1, 0, 2'b11, 16'h2000, 16'h0000, 1, 0};
      vecs[13] = '{0, 16'h0000, 0, 0, 2'b00, 16'h0000, 16'h0000, 1, 16'h3333, 0, 0, 2'b00, 16'h2000, 16'h0000, 0, 0};

      for (int k = 0; k < 14; k++) begin
         if (k != 0) @(negedge clk);
         i_mem_read = vecs[k].i_rd;  i_mem_address = vecs[k].i_addr;
         d_mem_read = vecs[k].d_rd;  d_mem_write = vecs[k].d_wr;
         d_mem_byte_enable = vecs[k].be;
         d_mem_address = vecs[k].d_addr; d_mem_wdata = vecs[k].d_wd;
         pmem_resp = vecs[k].presp; pmem_rdata = vecs[k].prdata;
         #1;
         chk($sformatf("vec%0d_read", k), {31'd0, pmem_read}, {31'd0, vecs[k].e_rd});
         chk($sformatf("vec%0d_write", k), {31'd0, pmem_write}, {31'd0, vecs[k].e_wr});
         chk($sformatf("vec%0d_be", k), {30'd0, pmem_byte_enable}, {30'd0, vecs[k].e_be});
         chk($sformatf("vec%0d_addr", k), {16'd0, pmem_address}, {16'd0, vecs[k].e_addr});
         chk($sformatf("vec%0d_wdata", k), {16'd0, pmem_wdata}, {16'd0, vecs[k].e_wd});
         chk($sformatf("vec%0d_iresp", k), {31'd0, i_mem_resp}, {31'd0, vecs[k].e_iresp});
         chk($sformatf("vec%0d_dresp", k), {31'd0, d_mem_resp}, {31'd0, vecs[k].e_dresp});
         if (vecs[k].e_iresp)
            chk($sformatf("vec%0d_irdata", k), {16'd0, i_mem_rdata}, {16'd0, vecs[k].prdata});
         if (vecs[k].e_dresp)
            chk($sformatf("vec%0d_drdata", k), {16'd0, d_mem_rdata}, {16'd0, vecs[k].prdata});
      end

      // Both clients requesting continuously: I is served after every MAXS data grants.
      do_reset();
      i_mem_read = 1; i_mem_address = 16'h0100;
      d_mem_read = 1; d_mem_address = 16'h0D00;
      collect(10, 1'b1, seq);
      checks++;
      if (seq != "DDDDIDDDDI") begin
         errors++;
         $display("FAIL starvation_seq actual=%s expected=DDDDIDDDDI", seq);
      end

      // Reset in D_BUSY with a full streak: everything drops at once, streak restarts.
      do_reset();
      i_mem_read = 1; i_mem_address = 16'h0100;
      d_mem_read = 1; d_mem_write = 1; d_mem_byte_enable = 2'b10;
      d_mem_address = 16'h0D00; d_mem_wdata = 16'h7777;
      collect(4, 1'b0, seq);
      @(negedge clk);
      pmem_resp = 1;
      #1;
      chk("pre_reset_write", {31'd0, pmem_write}, 32'd1);
      chk("pre_reset_dresp", {31'd0, d_mem_resp}, 32'd1);
      rst_n = 0;
      #1;
      chk_all_zero("midreset");
      @(negedge clk);
      pmem_resp = 0;
      rst_n = 1;
      collect(5, 1'b1, seq);
      checks++;
      if (seq != "DDDDI") begin
         errors++;
         $display("FAIL post_reset_seq actual=%s expected=DDDDI", seq);
      end

      // Randomized traffic against the reference model.
      do_reset();
      m_busy = 0; m_is_d = 0; m_rd = 0; m_wr = 0; m_be = 0;
      m_addr = 0; m_wd = 0; m_d_run = 0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         i_mem_read        = ($urandom_range(0, 3) != 0);
         i_mem_address     = 16'($urandom);
         d_mem_read        = ($urandom_range(0, 2) == 0);
         d_mem_write       = ($urandom_range(0, 3) == 0);
         d_mem_byte_enable = 2'($urandom);
         d_mem_address     = 16'($urandom);
         d_mem_wdata       = 16'($urandom);
         pmem_resp         = ($urandom_range(0, 2) == 0);
         pmem_rdata        = 16'($urandom);
         #1;
         chk("rnd_read", {31'd0, pmem_read}, {31'd0, m_rd});
         chk("rnd_write", {31'd0, pmem_write}, {31'd0, m_wr});
         chk("rnd_be", {30'd0, pmem_byte_enable}, {30'd0, m_be});
         chk("rnd_addr", {16'd0, pmem_address}, {16'd0, m_addr});
         chk("rnd_wdata", {16'd0, pmem_wdata}, {16'd0, m_wd});
         chk("rnd_iresp", {31'd0, i_mem_resp}, {31'd0, m_busy && !m_is_d && pmem_resp});
         chk("rnd_dresp", {31'd0, d_mem_resp}, {31'd0, m_busy && m_is_d && pmem_resp});
         if (m_busy && pmem_resp)
            chk("rnd_rdata", {16'd0, (m_is_d ? d_mem_rdata : i_mem_rdata)}, {16'd0, pmem_rdata});

         if (m_busy) begin
            if (pmem_resp) begin
               m_busy = 0; m_rd = 0; m_wr = 0; m_be = 2'b00;
            end
         end else if ((d_mem_read || d_mem_write) && !(i_mem_read && m_d_run >= MAXS)) begin
            m_busy = 1; m_is_d = 1;
            m_addr = d_mem_address; m_wd = d_mem_wdata;
            m_wr = d_mem_write; m_rd = !d_mem_write;
            m_be = d_mem_write ? d_mem_byte_enable : 2'b11;
            m_d_run = i_mem_read ? m_d_run + 1 : 0;
         end else if (i_mem_read) begin
            m_busy = 1; m_is_d = 0;
            m_addr = i_mem_address; m_wd = '0;
            m_rd = 1; m_wr = 0; m_be = 2'b11;
            m_d_run = 0;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
